// File: rtl/keypad_stim_driver.sv
// Keypad stimulus driver: queues 5-bit key codes and plays them as timed one-hot presses on pb_out.
// Optional build macro KEYDRV_AUTOPW_EN adds pw/play ports for a W-plus-8-nibble password replay.
module keypad_stim_driver #(
  parameter int DEPTH     = 8,
  parameter int PRESS_CYC = 10,
  parameter int GAP_CYC   = 10
) (
  input  logic                     hz100,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [4:0]               key_code,
`ifdef KEYDRV_AUTOPW_EN
  input  logic [31:0]              pw,
  input  logic                     play,
`endif
  output logic                     key_ready,
  output logic [19:0]              pb_out,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int MAXC = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] PRESS_LD = CW'(PRESS_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t        state, state_n;
  logic [4:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_n;
  logic [19:0]   pb_n;
  logic          done_n, accept, push, pop, replay;

  // Ready comes from registered occupancy only, so a full FIFO never passes a key through.
  assign key_ready = (level < LW'(DEPTH)) && !replay;
  assign accept    = key_valid && key_ready;
  assign push      = accept && (key_code < 5'd20);
  assign busy      = (state != IDLE) || (level != '0) || replay;

`ifdef KEYDRV_AUTOPW_EN
  logic [31:0] pw_sr;
  logic [3:0]  rp_left;
  logic        rp_start, rp_load, rp_end;
`else
  assign replay = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pb_n    = pb_out;
    cnt_n   = cnt;
    done_n  = 1'b0;
    pop     = 1'b0;
`ifdef KEYDRV_AUTOPW_EN
    rp_start = 1'b0;
    rp_load  = 1'b0;
    rp_end   = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef KEYDRV_AUTOPW_EN
        if (replay) begin
          rp_load = 1'b1;
          pb_n    = 20'd1 << pw_sr[31:28];
          cnt_n   = PRESS_LD;
          state_n = PRESS;
        end else if (level == '0) begin
          if (play) begin
            rp_start = 1'b1;
            pb_n     = 20'd1 << 5'd16;
            cnt_n    = PRESS_LD;
            state_n  = PRESS;
          end
        end else
`endif
        if (level != '0) begin
          pop     = 1'b1;
          pb_n    = 20'd1 << mem[rd_ptr];
          cnt_n   = PRESS_LD;
          state_n = PRESS;
        end
      end
      PRESS: begin
        if (cnt == '0) begin
          pb_n    = '0;
          cnt_n   = GAP_LD;
          state_n = GAP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
`ifdef KEYDRV_AUTOPW_EN
          // Intermediate replay gaps end silently; only the last one may report done.
          if (!(replay && rp_left != '0)) begin
            rp_end = replay;
            done_n = (level == '0) && !push;
          end
`else
          done_n = (level == '0) && !push;
`endif
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pb_out <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_n;
      pb_out <= pb_n;
      cnt    <= cnt_n;
      done   <= done_n;
      err    <= accept && (key_code >= 5'd20);
      level  <= level + LW'(push) - LW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge hz100) begin
    if (push) mem[wr_ptr] <= key_code;
  end

`ifdef KEYDRV_AUTOPW_EN
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      replay  <= 1'b0;
      pw_sr   <= '0;
      rp_left <= '0;
    end else begin
      if (rp_start) begin
        replay  <= 1'b1;
        pw_sr   <= pw;
        rp_left <= 4'd8;
      end else if (rp_load) begin
        pw_sr   <= {pw_sr[27:0], 4'h0};
        rp_left <= rp_left - 1'b1;
      end
      if (rp_end) replay <= 1'b0;
    end
  end
`endif

endmodule
